// File: rtl/fcs_tx_inserter_pkg.sv
// Shared definitions for the transmit FCS inserter.
//
// Contents:
//   state_e          one-hot controller state encoding
//   CRC32_POLY_REFL  reflected CRC-32 polynomial
//   CRC32_INIT       CRC register value at the start of every frame
//   crc32_byte()     folds one byte into a reflected CRC-32 register
package fcs_tx_pkg;

    typedef enum logic [4:0] {
        ST_IDLE = 5'b00001,
        ST_DATA = 5'b00010,
        ST_PAD  = 5'b00100,
        ST_FCS  = 5'b01000,
        ST_GAP  = 5'b10000
    } state_e;

    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;

    // LSB-first bit-serial form unrolled over one byte. The result is the
    // raw register value; the FCS on the wire is its complement.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                               input logic [7:0]  data);
        logic [31:0] c;
        c = crc ^ {24'h000000, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/fcs_tx_inserter_crc32_byte_upd.sv
// Combinational single-byte step of the reflected CRC-32.
//
// Ports:
//   crc_in   current CRC register value
//   data_in  byte to fold in
//   crc_out  CRC register value after folding data_in
module crc32_byte_upd
    import fcs_tx_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data_in,
    output logic [31:0] crc_out
);

    assign crc_out = crc32_byte(crc_in, data_in);

endmodule

// File: rtl/fcs_tx_inserter.sv
// Byte-stream Ethernet TX FCS inserter with ready/valid on both sides.
// Pads short frames with zeros up to MIN_LEN, appends the CRC-32 FCS
// (LSB byte first), then holds off input for IFG cycles. Frames flagged
// with in_bypass on their sop beat pass through untouched.
//
// Ports:
//   clk, reset_b                  clock, async active-low reset
//   in_valid/in_ready/in_data     input byte handshake
//   in_sop/in_eop                 frame delimiters on the input
//   in_bypass                     per-frame bypass, sampled with sop
//   out_valid/out_ready/out_data  output byte handshake (single register)
//   out_sop/out_eop               frame delimiters on the output
//   err_pulse                     one-cycle pulse on a protocol error
//   stat_frames, stat_padded      wrapping frame / padded-frame counters
//
// State | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for an sop byte; non-sop bytes are dropped (error)
// DATA  | forwarding frame bytes, folding them into the CRC
// PAD   | emitting 0x00 bytes until the frame reaches MIN_LEN
// FCS   | emitting the four complemented CRC bytes, eop on the last
// GAP   | eop beat draining downstream, then IFG idle cycles
module fcs_tx_inserter
    import fcs_tx_pkg::*;
#(
    parameter int MIN_LEN = 60,
    parameter int IFG     = 12,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset_b,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             in_sop,
    input  logic             in_eop,
    input  logic             in_bypass,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             out_sop,
    output logic             out_eop,
    output logic             err_pulse,
    output logic [CNT_W-1:0] stat_frames,
    output logic [CNT_W-1:0] stat_padded
);

    localparam int LEN_W = (MIN_LEN > 1) ? $clog2(MIN_LEN + 1) : 1;
    localparam int GAP_W = (IFG > 1) ? $clog2(IFG + 1) : 1;
    localparam logic [LEN_W-1:0] MIN_LEN_L = LEN_W'(MIN_LEN);
    // Length after the sop byte; stays 0 when padding is disabled so the
    // saturation rule holds from the first byte.
    localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'((MIN_LEN > 0) ? 1 : 0);
    localparam logic [GAP_W-1:0] GAP_LOAD  = GAP_W'(IFG);
    localparam state_e           AFTER_EOP = (IFG == 0) ? ST_IDLE : ST_GAP;

    state_e             state_q, state_d;
    logic [31:0]        crc_q, crc_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               bypass_q, bypass_d;
    logic [1:0]         fcs_idx_q, fcs_idx_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic               out_valid_q, out_valid_d;
    logic [7:0]         out_data_q, out_data_d;
    logic               out_sop_q, out_sop_d;
    logic               out_eop_q, out_eop_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   stat_frames_q, stat_frames_d;
    logic [CNT_W-1:0]   stat_padded_q, stat_padded_d;
    // Keeps in_ready low while reset is asserted and for the first cycle after.
    logic               live_q, live_d;

    logic               adv;
    logic               in_fire;
    logic               out_fire;
    logic [31:0]        crc_seed;
    logic [7:0]         crc_byte_in;
    logic [31:0]        crc_next;
    logic [LEN_W-1:0]   len_inc;
    logic [LEN_W-1:0]   len_new;
    logic               eof_bypass;

    assign adv      = ~out_valid_q | out_ready;
    assign in_ready = live_q & adv & ((state_q == ST_IDLE) | (state_q == ST_DATA));
    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid_q & out_ready;

    // An sop byte always restarts the CRC, so the seed is chosen by state
    // rather than by clearing the register at the end of each frame.
    assign crc_seed    = (state_q == ST_IDLE) ? CRC32_INIT : crc_q;
    assign crc_byte_in = (state_q == ST_PAD) ? 8'h00 : in_data;

    crc32_byte_upd u_crc (
        .crc_in  (crc_seed),
        .data_in (crc_byte_in),
        .crc_out (crc_next)
    );

    assign len_inc    = (len_q < MIN_LEN_L) ? len_q + LEN_W'(1) : len_q;
    assign len_new    = (state_q == ST_IDLE) ? LEN_ONE : len_inc;
    assign eof_bypass = (state_q == ST_IDLE) ? in_bypass : bypass_q;

    always_comb begin
        state_d       = state_q;
        crc_d         = crc_q;
        len_d         = len_q;
        bypass_d      = bypass_q;
        fcs_idx_d     = fcs_idx_q;
        gap_cnt_d     = gap_cnt_q;
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        out_sop_d     = out_sop_q;
        out_eop_d     = out_eop_q;
        err_d         = 1'b0;
        live_d        = 1'b1;
        stat_padded_d = stat_padded_q;
        stat_frames_d = stat_frames_q;

        if (out_fire && out_eop_q) begin
            stat_frames_d = stat_frames_q + CNT_W'(1);
        end

        if (adv) begin
            // The output register empties unless a state below loads a beat.
            out_valid_d = 1'b0;
            out_data_d  = 8'h00;
            out_sop_d   = 1'b0;
            out_eop_d   = 1'b0;

            case (state_q)
                ST_IDLE, ST_DATA: begin
                    if (in_fire) begin
                        if ((state_q == ST_IDLE) && !in_sop) begin
                            err_d = 1'b1;
                        end else begin
                            err_d       = (state_q == ST_DATA) && in_sop;
                            out_valid_d = 1'b1;
                            out_data_d  = in_data;
                            out_sop_d   = (state_q == ST_IDLE);
                            crc_d       = crc_next;
                            len_d       = len_new;
                            bypass_d    = eof_bypass;
                            state_d     = ST_DATA;
                            if (in_eop) begin
                                if (eof_bypass) begin
                                    out_eop_d = 1'b1;
                                    state_d   = AFTER_EOP;
                                    gap_cnt_d = GAP_LOAD;
                                end else if (len_new < MIN_LEN_L) begin
                                    state_d       = ST_PAD;
                                    stat_padded_d = stat_padded_q + CNT_W'(1);
                                end else begin
                                    state_d   = ST_FCS;
                                    fcs_idx_d = 2'd0;
                                end
                            end
                        end
                    end
                end

                ST_PAD: begin
                    out_valid_d = 1'b1;
                    crc_d       = crc_next;
                    len_d       = len_inc;
                    if (len_inc == MIN_LEN_L) begin
                        state_d   = ST_FCS;
                        fcs_idx_d = 2'd0;
                    end
                end

                ST_FCS: begin
                    out_valid_d = 1'b1;
                    out_data_d  = ~crc_q[{fcs_idx_q, 3'b000} +: 8];
                    fcs_idx_d   = fcs_idx_q + 2'd1;
                    if (fcs_idx_q == 2'd3) begin
                        out_eop_d = 1'b1;
                        state_d   = AFTER_EOP;
                        gap_cnt_d = GAP_LOAD;
                    end
                end

                ST_GAP: begin
                    // While out_valid_q is set the eop beat is still ours and
                    // is being taken this cycle; the gap starts afterwards.
                    if (!out_valid_q) begin
                        if (gap_cnt_q <= GAP_W'(1)) begin
                            state_d = ST_IDLE;
                        end else begin
                            gap_cnt_d = gap_cnt_q - GAP_W'(1);
                        end
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q       <= ST_IDLE;
            crc_q         <= CRC32_INIT;
            len_q         <= '0;
            bypass_q      <= 1'b0;
            fcs_idx_q     <= 2'd0;
            gap_cnt_q     <= '0;
            out_valid_q   <= 1'b0;
            out_data_q    <= 8'h00;
            out_sop_q     <= 1'b0;
            out_eop_q     <= 1'b0;
            err_q         <= 1'b0;
            live_q        <= 1'b0;
            stat_frames_q <= '0;
            stat_padded_q <= '0;
        end else begin
            state_q       <= state_d;
            crc_q         <= crc_d;
            len_q         <= len_d;
            bypass_q      <= bypass_d;
            fcs_idx_q     <= fcs_idx_d;
            gap_cnt_q     <= gap_cnt_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_sop_q     <= out_sop_d;
            out_eop_q     <= out_eop_d;
            err_q         <= err_d;
            live_q        <= live_d;
            stat_frames_q <= stat_frames_d;
            stat_padded_q <= stat_padded_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_sop     = out_sop_q;
    assign out_eop     = out_eop_q;
    assign err_pulse   = err_q;
    assign stat_frames = stat_frames_q;
    assign stat_padded = stat_padded_q;

endmodule

// File: tb/tb_fcs_tx_inserter.sv
module tb_fcs_tx_inserter;

    typedef logic [7:0] bq_t[$];

    localparam logic [31:0] POLY = 32'hEDB88320;

    logic       clk = 1'b0;
    logic       reset_b = 1'b0;
    logic       sel = 1'b0;
    logic       in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0, in_bypass = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] in_data = 8'h00;

    logic        a_in_ready, a_out_valid, a_out_sop, a_out_eop, a_err;
    logic [7:0]  a_out_data;
    logic [31:0] a_frames, a_padded;
    logic        b_in_ready, b_out_valid, b_out_sop, b_out_eop, b_err;
    logic [7:0]  b_out_data;
    logic [31:0] b_frames, b_padded;

    logic        in_ready_m, out_valid_m, out_sop_m, out_eop_m, err_m;
    logic [7:0]  out_data_m;
    logic [31:0] frames_m, padded_m;

    fcs_tx_inserter #(.MIN_LEN(0), .IFG(0), .CNT_W(32)) dut_a (
        .clk(clk), .reset_b(reset_b),
        .in_valid(in_valid & ~sel), .in_ready(a_in_ready), .in_data(in_data),
        .in_sop(in_sop), .in_eop(in_eop), .in_bypass(in_bypass),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
        .out_sop(a_out_sop), .out_eop(a_out_eop), .err_pulse(a_err),
        .stat_frames(a_frames), .stat_padded(a_padded)
    );

    fcs_tx_inserter #(.MIN_LEN(60), .IFG(12), .CNT_W(32)) dut_b (
        .clk(clk), .reset_b(reset_b),
        .in_valid(in_valid & sel), .in_ready(b_in_ready), .in_data(in_data),
        .in_sop(in_sop), .in_eop(in_eop), .in_bypass(in_bypass),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
        .out_sop(b_out_sop), .out_eop(b_out_eop), .err_pulse(b_err),
        .stat_frames(b_frames), .stat_padded(b_padded)
    );

    assign in_ready_m  = sel ? b_in_ready  : a_in_ready;
    assign out_valid_m = sel ? b_out_valid : a_out_valid;
    assign out_data_m  = sel ? b_out_data  : a_out_data;
    assign out_sop_m   = sel ? b_out_sop   : a_out_sop;
    assign out_eop_m   = sel ? b_out_eop   : a_out_eop;
    assign err_m       = sel ? b_err       : a_err;
    assign frames_m    = sel ? b_frames    : a_frames;
    assign padded_m    = sel ? b_padded    : a_padded;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;
    int last_in_cyc = 0;
    int first_in_cyc = 0;
    logic [31:0] crc_tbl[256];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Table-driven CRC-32 over a whole byte array; returns the FCS value.
    function automatic logic [31:0] ref_fcs(input bq_t f);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (f[i]) c = crc_tbl[(c[7:0] ^ f[i])] ^ (c >> 8);
        return ~c;
    endfunction

    function automatic bq_t model(input bq_t f, input bit byp, input int min_len);
        bq_t o;
        logic [31:0] fcs;
        o = f;
        if (!byp) begin
            while (o.size() < min_len) o.push_back(8'h00);
            fcs = ref_fcs(o);
            for (int k = 0; k < 4; k++) o.push_back(fcs[8*k +: 8]);
        end
        return o;
    endfunction

    function automatic bq_t rand_frame(input int n);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    task automatic drive_byte(input logic [7:0] d, input bit sop, input bit eop, input bit byp);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1; in_data = d; in_sop = sop; in_eop = eop; in_bypass = byp;
        forever begin
            #4;
            if (in_ready_m) begin
                last_in_cyc = cyc;
                @(posedge clk);
                return;
            end
            n++;
            if (n > 1000) begin
                chk("in_timeout", 64'd0, 64'd1);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic send_frame(input bq_t f, input bit byp);
        for (int i = 0; i < f.size(); i++) begin
            drive_byte(f[i], (i == 0), (i == f.size() - 1), byp);
            if (i == 0) first_in_cyc = last_in_cyc;
        end
    endtask

    task automatic idle_in();
        @(negedge clk);
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_bypass = 1'b0;
    endtask

    task automatic collect(input bit rnd, output bq_t d, output bq_t fl,
                           output int c_first, output int c_last);
        logic [9:0] prev;
        bit stalled;
        int n;
        d = {}; fl = {}; stalled = 1'b0; n = 0; c_first = 0; c_last = 0; prev = '0;
        forever begin
            @(negedge clk);
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #4;
            if (stalled) chk("stall_hold", {out_sop_m, out_eop_m, out_data_m}, prev);
            if (!out_valid_m) chk("idle_data", out_data_m, 8'h00);
            stalled = out_valid_m & ~out_ready;
            prev = {out_sop_m, out_eop_m, out_data_m};
            if (out_valid_m & out_ready) begin
                if (d.size() == 0) c_first = cyc;
                d.push_back(out_data_m);
                fl.push_back({6'b0, out_sop_m, out_eop_m});
                if (out_eop_m) begin
                    c_last = cyc;
                    break;
                end
            end
            n++;
            if (n > 3000) begin
                chk("out_timeout", 64'd0, 64'd1);
                break;
            end
        end
    endtask

    task automatic cmp_frame(input string tag, input bq_t d, input bq_t fl, input bq_t e);
        chk({tag, "_len"}, d.size(), e.size());
        for (int i = 0; i < d.size() && i < e.size(); i++) begin
            chk({tag, "_data"}, d[i], e[i]);
            chk({tag, "_flags"}, fl[i], {6'b0, (i == 0), (i == e.size() - 1)});
        end
    endtask

    initial begin
        bq_t f, f2, d, fl, d2, fl2;
        int c1, c2, s2, gap, n;
        logic [31:0] c;

        for (int i = 0; i < 256; i++) begin
            c = 32'(i);
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ POLY) : (c >> 1);
            crc_tbl[i] = c;
        end

        // Reset values on both instances
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            #1;
            chk("rst_in_ready", in_ready_m, 1'b0);
            chk("rst_out", {out_valid_m, out_sop_m, out_eop_m, out_data_m}, 11'h0);
            chk("rst_err", err_m, 1'b0);
            chk("rst_stats", {frames_m, padded_m}, 64'h0);
        end
        @(negedge clk);
        reset_b = 1'b1;
        sel = 1'b0;

        // Unpadded check vector, no backpressure, IFG 0
        f = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        fork
            send_frame(f, 1'b0);
            collect(1'b0, d, fl, c1, c2);
        join
        idle_in();
        cmp_frame("crc_vec", d, fl, model(f, 1'b0, 0));
        if (d.size() == 13) chk("crc_vec_fcs", {d[9], d[10], d[11], d[12]}, 32'h2639F4CB);
        chk("latency", c1 - first_in_cyc, 1);
        repeat (2) @(negedge clk);
        chk("a_frames", a_frames, 32'd1);
        chk("a_padded", a_padded, 32'd0);

        // Padded 14-byte frame
        sel = 1'b1;
        f = rand_frame(14);
        fork
            send_frame(f, 1'b0);
            collect(1'b0, d, fl, c1, c2);
        join
        idle_in();
        cmp_frame("pad14", d, fl, model(f, 1'b0, 60));
        repeat (2) @(negedge clk);
        chk("pad_count", b_padded, 32'd1);
        chk("pad_frames", b_frames, 32'd1);

        // Bypass 20-byte frame
        f = rand_frame(20);
        fork
            send_frame(f, 1'b1);
            collect(1'b0, d, fl, c1, c2);
        join
        idle_in();
        cmp_frame("bypass", d, fl, model(f, 1'b1, 60));
        repeat (2) @(negedge clk);
        chk("byp_padded", b_padded, 32'd1);
        chk("byp_frames", b_frames, 32'd2);

        // 64-byte frame with random backpressure
        f = rand_frame(64);
        fork
            send_frame(f, 1'b0);
            collect(1'b1, d, fl, c1, c2);
        join
        idle_in();
        cmp_frame("bp64", d, fl, model(f, 1'b0, 60));
        repeat (2) @(negedge clk);
        chk("bp_padded", b_padded, 32'd1);
        chk("bp_frames", b_frames, 32'd3);

        // Back-to-back frames: inter-frame gap
        f = rand_frame(8);
        f2 = rand_frame(8);
        gap = 0;
        fork
            begin
                send_frame(f, 1'b0);
                send_frame(f2, 1'b0);
            end
            begin
                collect(1'b0, d, fl, c1, c2);
                collect(1'b0, d2, fl2, s2, n);
            end
            begin
                n = 0;
                do begin
                    @(negedge clk); #4; n++;
                end while (!(out_valid_m & out_ready & out_eop_m) && n < 3000);
                n = 0;
                forever begin
                    @(negedge clk); #4;
                    if (in_ready_m || n > 100) break;
                    n++;
                end
                gap = n;
            end
        join
        idle_in();
        chk("ifg_cycles", gap, 12);
        chk("ifg_next_sop", s2 - c2, 14);
        cmp_frame("b2b_1", d, fl, model(f, 1'b0, 60));
        cmp_frame("b2b_2", d2, fl2, model(f2, 1'b0, 60));

        // Stray byte in IDLE
        repeat (20) @(negedge clk);
        drive_byte(8'hA5, 1'b0, 1'b0, 1'b0);
        idle_in();
        #4;
        chk("stray_err", err_m, 1'b1);
        chk("stray_noout", out_valid_m, 1'b0);
        @(negedge clk); #4;
        chk("stray_err_end", err_m, 1'b0);
        chk("stray_noout2", out_valid_m, 1'b0);

        // Reset mid-frame
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) drive_byte(8'($urandom), (i == 0), 1'b0, 1'b0);
        @(negedge clk);
        reset_b = 1'b0;
        in_valid = 1'b0; in_sop = 1'b0;
        #1;
        chk("mid_rst_out", {out_valid_m, out_sop_m, out_eop_m, out_data_m}, 11'h0);
        chk("mid_rst_ready", in_ready_m, 1'b0);
        chk("mid_rst_stats", {frames_m, padded_m}, 64'h0);
        @(negedge clk);
        reset_b = 1'b1;
        repeat (2) @(negedge clk);
        f = rand_frame(10);
        fork
            send_frame(f, 1'b0);
            collect(1'b0, d, fl, c1, c2);
        join
        idle_in();
        cmp_frame("post_rst", d, fl, model(f, 1'b0, 60));
        repeat (2) @(negedge clk);
        chk("post_rst_frames", b_frames, 32'd1);
        chk("post_rst_padded", b_padded, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fcs_tx_inserter.md
Name: fcs_tx_inserter

Overview:
- Byte-stream Ethernet transmit FCS inserter with ready/valid backpressure on both sides.
- Pads frames to a programmable minimum length, appends a CRC-32 FCS, then enforces an inter-frame gap.
- Per-frame bypass passes pre-formed frames through unchanged.
- Sits between the frame builder and the GMII/XGMII-lite TX adapter; successor to the fixed, unpadded, non-backpressured FCS appender.

Parameters:
MIN_LEN, 60, minimum payload bytes before FCS; shorter frames are zero-padded up to this length (0 disables padding)
IFG, 12, idle output cycles forced after each out_eop (0 allowed)
CNT_W, 32, width of statistics counters

Ports:
clk  in  1  clock
reset_b  in  1  asynchronous active-low reset
in_valid  in  1  input byte valid
in_ready  out  1  block accepts the input byte this cycle
in_data  in  8  input byte
in_sop  in  1  first byte of frame
in_eop  in  1  last byte of frame
in_bypass  in  1  sampled with the sop beat: 1 = no pad, no FCS, for this frame
out_valid  out  1  output byte valid
out_ready  in  1  downstream accepts output byte
out_data  out  8  output byte
out_sop  out  1  first output byte of frame
out_eop  out  1  last output byte of frame (last FCS byte, or last data byte in bypass)
err_pulse  out  1  one-cycle pulse on protocol error
stat_frames  out  CNT_W  frames completed on the output (wraps)
stat_padded  out  CNT_W  frames that received padding (wraps)

Behaviour:
- Reset values: in_ready 0, all out_* 0, err_pulse 0, counters 0, state IDLE, CRC 0xFFFFFFFF. A reset mid-frame discards the partial frame; no eop is emitted.
- Transfers: input on in_valid&in_ready; output on out_valid&out_ready.
- The output stage is a single registered beat. A new beat loads when adv = ~out_valid | out_ready.
- in_ready = adv & (state==IDLE | state==DATA).
- Latency: exactly 1 cycle from an accepted input byte to out_valid when there is no backpressure.
- Output beats are never dropped or altered while out_valid=1 and out_ready=0.
- States: IDLE, DATA, PAD, FCS, GAP. All transitions occur only on adv.
- IDLE:
  - Accepted byte with in_sop: emit it with out_sop=1, latch in_bypass, start CRC from 0xFFFFFFFF and fold in the byte, set len=1.
  - Then go to DATA, or handle as end of frame immediately if in_eop=1.
  - Accepted byte without in_sop: consume and drop it, pulse err_pulse, stay IDLE.
- DATA: each accepted byte is emitted, folded into the CRC, and increments len (len saturates at MIN_LEN).
  - An accepted byte with in_sop=1 in DATA is treated as ordinary data and pulses err_pulse.
- End of frame (the eop byte accepted):
  - Bypass: the eop byte carries out_eop=1 → GAP.
  - Otherwise, len<MIN_LEN → PAD.
  - Otherwise → FCS.
- PAD: emit 0x00 bytes folded into the CRC until len==MIN_LEN, then go to FCS. Increment stat_padded once per padded frame.
- FCS:
  - Emit 4 bytes in order ~crc[7:0], ~crc[15:8], ~crc[23:16], ~crc[31:24].
  - crc is the reflected CRC-32 (polynomial 0xEDB88320).
  - The fourth byte carries out_eop=1 → GAP.
- GAP: hold in_ready=0 for IFG cycles counted after the out_eop beat is accepted downstream → IDLE. IFG=0 goes straight to IDLE.
- stat_frames increments when an out_eop beat is accepted.
- A single-byte frame (sop&eop together) is legal: it is padded to MIN_LEN, or emitted as sop&eop in bypass.
- out_data=0x00 whenever out_valid=0.

Decomposition:
- Package fcs_tx_pkg holds: state encoding (one-hot, 5 bits), CRC32_POLY_REFL=32'hEDB88320, CRC32_INIT=32'hFFFFFFFF, and the byte-update function crc32_byte(crc, data).
- One sub-module, crc32_byte_upd: combinational 8-bit reflected CRC step. The top block holds the CRC register and controls init/enable.

Test Plan:
- MIN_LEN=0, IFG=0, frame "123456789" (0x31..0x39), out_ready=1 → 13 bytes out: the data, then 26 39 F4 CB; out_eop on CB; stat_frames=1.
- MIN_LEN=60, 14-byte frame → 60 bytes out (14 data + 46×0x00), then 4 FCS bytes matching the reference model; stat_padded=1.
- Bypass frame of 20 bytes → identical 20 bytes out, eop on byte 20, no FCS, stat_padded unchanged.
- Random out_ready (50% toggling) on a 64-byte frame → output byte sequence identical to the no-backpressure run; out_data stable while stalled.
- IFG=12, back-to-back frames offered → exactly 12 cycles with in_ready=0 after the out_eop handshake; then the second out_sop.
- Stray byte in IDLE without sop → err_pulse for 1 cycle, no output; then reset_b low mid-frame → all outputs 0 and the next frame is processed cleanly.
